truth_table_sequencer: RTL
==========================

// Module: truth_table_sequencer
// PURPOSE
//   Sweeps every input combination of an N-input combinational gate network
//   (e.g. the NAND-only 3-input implementation). Per vector: drive, wait a
//   settle period, sample the single-bit output into a captured truth table.
//   Sits between the bench/host and the gate under test; replaces hand-coded
//   #20 stimulus lists with a clocked, restartable sweep.
// PARAMETERS
//   N_IN        3   number of DUT inputs; table depth = 2**N_IN (1..8)
//   SETTLE_CYC  4   clocks each vector is held before sampling (>=1)
// PORTS
//   clk         in   1          single clock, rising edge
//   rst         in   1          asynchronous, active-high reset
//   start       in   1          request sweep; accepted only in IDLE
//   busy        out  1          high from the cycle after accept until done
//   done        out  1          one-cycle pulse; sweep complete
//   vec_out     out  N_IN       drives DUT inputs; MSB = first input (L)
//   dut_y       in   1          DUT output (X)
//   sample_vld  out  1          one-cycle pulse when dut_y is captured
//   sample_idx  out  N_IN       index of the vector captured with sample_vld
//   tt          out  2**N_IN    captured table; tt[i] = dut_y for vec_out == i
//   exp_tt      in   2**N_IN    [TT_CHECK_EN only] expected table
//   mismatch    out  1          [TT_CHECK_EN only] sticky mismatch flag
//   err_idx     out  N_IN       [TT_CHECK_EN only] first failing index
// BEHAVIOUR
//   - Reset (any time, including mid-sweep): state=IDLE; busy, done,
//     sample_vld, vec_out, sample_idx, tt, mismatch, err_idx all 0.
//   - FSM: IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE) -> IDLE.
//   - IDLE: vec_out=0. On start=1: idx<=0, cnt<=0, tt<=0, mismatch<=0,
//     err_idx<=0, go SETTLE.
//   - SETTLE: vec_out=idx, busy=1; cnt increments; after SETTLE_CYC cycles
//     in SETTLE go SAMPLE.
//   - SAMPLE (1 cycle): tt[idx]<=dut_y; sample_vld=1, sample_idx=idx.
//     If idx==2**N_IN-1 go DONE, else idx<=idx+1, cnt<=0, go SETTLE.
//   - DONE (1 cycle): done=1, busy=0, vec_out holds last vector; -> IDLE.
//   - Latency: done high in cycle 2**N_IN*(SETTLE_CYC+1)+1 after the accept
//     edge (41 for defaults). start during SETTLE/SAMPLE/DONE ignored; start
//     held high in IDLE immediately after DONE begins a new sweep.
//   - idx is N_IN+1 bits internally; no wrap at last vector (terminates).
//   - tt stable after done until next accepted start or reset.
//   - dut_y sampled as-is; caller guarantees SETTLE_CYC covers DUT delay.
// CONFIGURATION
//   TT_CHECK_EN defined: exp_tt, mismatch, err_idx ports exist. In SAMPLE,
//     if dut_y != exp_tt[idx]: mismatch<=1; err_idx<=idx only on the first
//     mismatch of the sweep. Both valid at done, cleared on start/reset.
//   TT_CHECK_EN undefined: those ports and logic absent; tt is the only
//     result; all other timing identical.
// STRUCTURE
//   Package tt_seq_pkg: state enum {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE},
//     MAX_N_IN=8, localparam helper for table depth.
//   Sub-module settle_timer (clear, en -> expire after SETTLE_CYC cycles);
//     top holds FSM, index counter, table register, optional checker.
// TESTING (DUT = 3-input NAND network, defaults)
//   1. rst, start pulse -> done at cycle 41, tt==8'h7F, 8 sample_vld pulses
//      with sample_idx 0..7 in order, vec_out holds each value 5 cycles.
//   2. TT_CHECK_EN, exp_tt=8'h7F -> mismatch=0 at done.
//   3. TT_CHECK_EN, exp_tt=8'h7E -> mismatch=1, err_idx=0; exp_tt=8'hFF
//      -> mismatch=1, err_idx=7.
//   4. start re-pulsed at cycles 3 and 20 of a sweep -> ignored, done still
//      at 41, one done pulse only.
//   5. rst asserted during SETTLE of idx 4 (async, mid-cycle) -> all outputs
//      0 immediately; next start yields a full, correct sweep (tt==8'h7F).
//   6. start held high continuously -> back-to-back sweeps, done every 42
//      cycles, tt cleared to 0 at each accept.

Source files
------------

// File: rtl/tt_seq_pkg.sv
// rtl/tt_seq_pkg.sv - shared state encoding and sizing helpers for the truth table sequencer
package tt_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam int MAX_N_IN = 8;

  // Number of truth table rows for an n-input gate network
  function automatic int tt_depth(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// rtl/truth_table_sequencer_settle_timer.sv - counts the hold period of one vector before sampling
module settle_timer #(
  parameter int SETTLE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic [CW-1:0] r_cnt;

  // Expiry marks the last of SETTLE_CYC enabled cycles
  assign o_expire = i_en && (r_cnt == CW'(SETTLE_CYC - 1));

  // Count enabled cycles; the counter never passes its terminal value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - clocked truth table sweep of a gate network; TT_CHECK_EN adds an expected-table checker
module truth_table_sequencer
  import tt_seq_pkg::*;
#(
  parameter int N_IN       = 3,
  parameter int SETTLE_CYC = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      dut_y,
`ifdef TT_CHECK_EN
  input  logic [tt_depth(N_IN)-1:0] exp_tt,
  output logic                      mismatch,
  output logic [N_IN-1:0]           err_idx,
`endif
  output logic                      busy,
  output logic                      done,
  output logic [N_IN-1:0]           vec_out,
  output logic                      sample_vld,
  output logic [N_IN-1:0]           sample_idx,
  output logic [tt_depth(N_IN)-1:0] tt
);

  localparam int DEPTH = tt_depth(N_IN);

  state_t           r_state;
  state_t           w_next;
  logic [N_IN:0]    r_idx;
  logic [DEPTH-1:0] r_tt;
  logic             w_expire;
  logic             w_accept;
  logic             w_last;
  logic             w_settle;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_last   = (r_idx == (N_IN+1)'(DEPTH - 1));
  assign w_settle = (r_state == ST_SETTLE);
  assign tt       = r_tt;

  settle_timer #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clear (!w_settle),
    .i_en    (w_settle),
    .o_expire(w_expire)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and Moore outputs; vec_out keeps the last vector through DONE
  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    sample_vld = 1'b0;
    sample_idx = '0;
    vec_out    = r_idx[N_IN-1:0];
    case (r_state)
      ST_IDLE: begin
        vec_out = '0;
        if (start) w_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (w_expire) w_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        busy       = 1'b1;
        sample_vld = 1'b1;
        sample_idx = r_idx[N_IN-1:0];
        w_next     = w_last ? ST_DONE : ST_SETTLE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Vector index and captured table; index stops at the last row instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
      r_tt  <= '0;
    end else if (w_accept) begin
      r_idx <= '0;
      r_tt  <= '0;
    end else if (r_state == ST_SAMPLE) begin
      r_tt[r_idx[N_IN-1:0]] <= dut_y;
      if (!w_last) r_idx <= r_idx + (N_IN+1)'(1);
    end
  end

`ifdef TT_CHECK_EN
  logic            r_mismatch;
  logic [N_IN-1:0] r_err_idx;

  assign mismatch = r_mismatch;
  assign err_idx  = r_err_idx;

  // Sticky mismatch flag; only the first failing row of a sweep is recorded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mismatch <= 1'b0;
      r_err_idx  <= '0;
    end else if (w_accept) begin
      r_mismatch <= 1'b0;
      r_err_idx  <= '0;
    end else if ((r_state == ST_SAMPLE) && (dut_y != exp_tt[r_idx[N_IN-1:0]])) begin
      r_mismatch <= 1'b1;
      if (!r_mismatch) r_err_idx <= r_idx[N_IN-1:0];
    end
  end
`endif

endmodule
